hilo_div_unit: RTL and testbench
================================

// Module: hilo_div_unit
// PURPOSE
//   Multi-cycle divider plus HI/LO register file for the MIPS datapath. Sits beside the
//   combinational ALU: captures the ALU multiply result (lo/hi pair) and computes DIV/DIVU
//   iteratively, one quotient bit per cycle. Also serves MTHI/MTLO and continuously drives
//   HI/LO for MFHI/MFLO. The controller stalls on busy.
// PARAMETERS
//   WIDTH      32   operand, quotient and remainder width
//   CNT_W      6    iteration counter width; must satisfy 2**CNT_W > WIDTH
// PORTS
//   clk         in   1      rising-edge clock
//   rst_n       in   1      synchronous reset, active low
//   start       in   1      op request; sampled only in IDLE
//   op          in   2      00 DIVU, 01 DIV, 10 MTHI, 11 MTLO
//   a           in   WIDTH  dividend / MTHI-MTLO data
//   b           in   WIDTH  divisor
//   mult_we     in   1      capture ALU multiply result into HI/LO
//   mult_lo     in   WIDTH  ALU product low word
//   mult_hi     in   WIDTH  ALU product high word
//   busy        out  1      divide in progress (CALC or FIX)
//   done        out  1      1-cycle pulse: divide result written to HI/LO
//   div_zero    out  1      sticky until next divide start: last divisor was 0
//   hi          out  WIDTH  HI register (remainder / product high)
//   lo          out  WIDTH  LO register (quotient / product low)
// BEHAVIOUR
//   - One clock; reset is synchronous and active-low. rst_n=0 at a clock edge: state IDLE;
//     hi, lo, busy, done, div_zero, counter and datapath registers all 0. Also applies mid-divide:
//     the operation is abandoned, done is never pulsed.
//   - FSM IDLE -> CALC -> FIX -> IDLE.
//     IDLE: start & op[1]=0 -> latch |a|,|b| (per signedness) and signs, clear div_zero, go CALC.
//           start & op=MTHI -> hi<=a; op=MTLO -> lo<=a; stay IDLE, no busy, no done.
//           mult_we (no start) -> hi<=mult_hi, lo<=mult_lo next edge.
//           start and mult_we together: start wins, mult_we dropped.
//     CALC: WIDTH cycles of restoring division (shift remainder left, trial-subtract divisor,
//           set quotient bit); counter 0..WIDTH-1, then FIX.
//     FIX:  apply signs, write hi<=remainder, lo<=quotient, done<=1, go IDLE.
//   - Latency: start sampled at edge of cycle T; busy=1 cycles T+1..T+33; done=1 and HI/LO
//     valid in cycle T+34 only. A new start is accepted in that same cycle.
//   - start and mult_we while busy are ignored (no effect, not queued); HI/LO hold.
//   - Divisor 0: no trap; natural restoring result: lo=all ones, hi=dividend magnitude with
//     signed fix-up as below; div_zero=1 from FIX edge until the next divide start.
//   - Signed: quotient truncates toward zero; remainder takes dividend's sign.
//     Most-negative / -1: lo=0x80000000, hi=0 (no exception).
//   - All arithmetic modulo 2**WIDTH; magnitudes held in WIDTH bits (|0x80000000| fits unsigned).
// CONFIGURATION
//   HILO_DIV_SIGNED_EN defined: op=01 performs signed DIV as above.
//   Not defined: op=01 executes exactly as DIVU; sign registers and FIX negation logic are
//   compiled out; FIX still takes its cycle so latency is unchanged (34).
// STRUCTURE
//   Shared package hilo_div_pkg: op encodings (OP_DIVU, OP_DIV, OP_MTHI, OP_MTLO), state
//   encodings (ST_IDLE, ST_CALC, ST_FIX), DIV_LATENCY=34.
//   One sub-module: div_step (combinational single restoring iteration: rem_in, quo_in,
//   divisor -> rem_out, quo_out), instantiated once inside CALC datapath.
// TESTING
//   1 DIVU a=100 b=7 -> cycle T+34: done=1, lo=14, hi=2, div_zero=0; busy high exactly 33 cycles.
//   2 DIVU a=5 b=0 -> lo=0xFFFFFFFF, hi=5, div_zero=1; next DIVU 9/3 clears it -> lo=3, hi=0.
//   3 DIV a=0xFFFFFFF9(-7) b=2 -> with _EN: lo=0xFFFFFFFD, hi=0xFFFFFFFF; without: lo=0x7FFFFFFC, hi=1.
//     With _EN also a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000, hi=0.
//   4 IDLE mult_we hi=0x1 lo=0x2 -> next cycle hi=1, lo=2; MTHI a=0xAB -> hi=0xAB, lo=2;
//     mult_we or start pulsed during busy -> HI/LO unchanged until done, no second done.
//   5 start+mult_we same IDLE cycle (DIVU 8/2) -> mult data dropped; lo=4, hi=0 at T+34.
//   6 rst_n=0 at CALC cycle 10 -> next cycle busy=0, hi=lo=0, done stays 0; fresh DIVU then works.

Source files
------------

// File: rtl/hilo_div_pkg.sv
// Shared encodings for the HI/LO divide unit: op codes, FSM states, latency.
package hilo_div_pkg;

  localparam logic [1:0] OP_DIVU = 2'b00;
  localparam logic [1:0] OP_DIV  = 2'b01;
  localparam logic [1:0] OP_MTHI = 2'b10;
  localparam logic [1:0] OP_MTLO = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;

  // Cycles from the start-sampling edge to the cycle in which done is high.
  localparam int DIV_LATENCY = 34;

endpackage

// File: rtl/hilo_div_unit_div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder, trial-subtract the divisor, and keep the result only if
// it did not borrow.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] quo_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic [WIDTH-1:0] quo_out
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // Bit WIDTH of the trial difference is the borrow: set means "restore".
  always_comb begin
    shifted = {rem_in, quo_in[WIDTH-1]};
    trial   = shifted - {1'b0, divisor};
    if (!trial[WIDTH]) begin
      rem_out = trial[WIDTH-1:0];
      quo_out = {quo_in[WIDTH-2:0], 1'b1};
    end else begin
      rem_out = shifted[WIDTH-1:0];
      quo_out = {quo_in[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/hilo_div_unit.sv
// HI/LO register file with an iterative restoring divider (one quotient bit
// per cycle). Also captures multiply results and serves MTHI/MTLO.
// Define HILO_DIV_SIGNED_EN to make op=01 a signed DIV; otherwise it behaves
// as DIVU and the sign handling is compiled out (latency is unchanged).
module hilo_div_unit
  import hilo_div_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mult_we,
  input  logic [WIDTH-1:0] mult_lo,
  input  logic [WIDTH-1:0] mult_hi,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
  logic [WIDTH-1:0] rem_nx, quo_nx;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] hi_res, lo_res;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem_q),
    .quo_in  (quo_q),
    .divisor (dvs_q),
    .rem_out (rem_nx),
    .quo_out (quo_nx)
  );

`ifdef HILO_DIV_SIGNED_EN
  logic a_neg, b_neg;
  logic q_neg, r_neg;

  // Operand magnitudes and final sign fix-up; quotient truncates toward zero,
  // remainder follows the dividend. |most-negative| still fits in WIDTH bits.
  always_comb begin
    a_neg  = (op == OP_DIV) && a[WIDTH-1];
    b_neg  = (op == OP_DIV) && b[WIDTH-1];
    a_mag  = a_neg ? -a : a;
    b_mag  = b_neg ? -b : b;
    lo_res = q_neg ? -quo_q : quo_q;
    hi_res = r_neg ? -rem_q : rem_q;
  end
`else
  assign a_mag  = a;
  assign b_mag  = b;
  assign lo_res = quo_q;
  assign hi_res = rem_q;
`endif

  assign busy = (state != ST_IDLE);

  // Control FSM, divider datapath and HI/LO write ports.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
      div_zero <= 1'b0;
`ifdef HILO_DIV_SIGNED_EN
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            // start beats a coincident mult_we
            if (!op[1]) begin
              rem_q    <= '0;
              quo_q    <= a_mag;
              dvs_q    <= b_mag;
              cnt      <= '0;
              div_zero <= 1'b0;
`ifdef HILO_DIV_SIGNED_EN
              q_neg    <= a_neg ^ b_neg;
              r_neg    <= a_neg;
`endif
              state    <= ST_CALC;
            end else if (op == OP_MTHI) begin
              hi <= a;
            end else begin
              lo <= a;
            end
          end else if (mult_we) begin
            hi <= mult_hi;
            lo <= mult_lo;
          end
        end
        ST_CALC: begin
          rem_q <= rem_nx;
          quo_q <= quo_nx;
          cnt   <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH - 1)) state <= ST_FIX;
        end
        ST_FIX: begin
          hi       <= hi_res;
          lo       <= lo_res;
          done     <= 1'b1;
          div_zero <= (dvs_q == '0);
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_div_unit.sv
// Self-checking bench for hilo_div_unit: directed cases plus randomized
// divides compared against a plain-arithmetic reference model.
module tb_hilo_div_unit;
  import hilo_div_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        mult_we;
  logic [31:0] mult_lo, mult_hi;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;

  hilo_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .mult_we  (mult_we),
    .mult_lo  (mult_lo),
    .mult_hi  (mult_hi),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  // Reference: ordinary integer division; signed mode uses 64-bit signed math
  // (truncating /, dividend-signed %). Divide by zero gives quotient magnitude
  // all ones and remainder magnitude |a|, with the usual signs applied.
  function automatic void model(input logic [1:0] op_i, input logic [31:0] a_i,
                                input logic [31:0] b_i,
                                output logic [31:0] q, output logic [31:0] r);
    bit     sgn;
    longint sa, sb, qq, rr;
    sgn = 1'b0;
`ifdef HILO_DIV_SIGNED_EN
    sgn = (op_i == OP_DIV);
`endif
    if (!sgn) begin
      if (b_i == 0) begin q = 32'hFFFF_FFFF; r = a_i; end
      else begin q = a_i / b_i; r = a_i % b_i; end
    end else begin
      sa = $signed(a_i);
      sb = $signed(b_i);
      if (sb == 0) begin
        qq = (sa < 0) ? -longint'(32'hFFFF_FFFF) : longint'(32'hFFFF_FFFF);
        rr = sa;
      end else begin
        qq = sa / sb;
        rr = sa % sb;
      end
      q = qq[31:0];
      r = rr[31:0];
    end
  endfunction

  // Issue a divide at the current negedge and follow it until done or timeout.
  // done_at is the cycle index (1 = cycle after the start edge), -1 on timeout.
  task automatic run_div(input logic [1:0] op_i, input logic [31:0] a_i,
                         input logic [31:0] b_i, output int done_at, output int busy_n);
    start = 1'b1; op = op_i; a = a_i; b = b_i;
    busy_n = 0; done_at = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) begin start = 1'b0; mult_we = 1'b0; end
      if (busy) busy_n++;
      if (done) begin done_at = k; break; end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
    mult_we = 1'b0; mult_lo = '0; mult_hi = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, div_zero, hi, lo} !== 67'd0) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b dz=%b hi=%h lo=%h, required all 0",
               busy, done, div_zero, hi, lo);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_divu();
    int da, bn;
    logic [31:0] ea, eb, q, r;
    run_div(OP_DIVU, 32'd100, 32'd7, da, bn);
    checks++;
    if (da !== DIV_LATENCY || bn !== 33) begin
      errors++;
      $display("FAIL divu_latency: done_at=%0d busy_cycles=%0d, required %0d and 33", da, bn, DIV_LATENCY);
    end
    checks++;
    if (lo !== 32'd14 || hi !== 32'd2 || div_zero !== 1'b0) begin
      errors++;
      $display("FAIL divu_100_7: lo=%0d hi=%0d dz=%b, required 14 2 0", lo, hi, div_zero);
    end
    for (int i = 0; i < 20; i++) begin
      ea = $urandom;
      eb = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 50)) : 32'($urandom);
      if (eb == 0) eb = 32'd3;
      model(OP_DIVU, ea, eb, q, r);
      run_div(OP_DIVU, ea, eb, da, bn);
      checks++;
      if (da !== DIV_LATENCY || lo !== q || hi !== r) begin
        errors++;
        $display("FAIL divu_rand: %h/%h got lo=%h hi=%h at %0d, required lo=%h hi=%h at %0d",
                 ea, eb, lo, hi, da, q, r, DIV_LATENCY);
      end
    end
  endtask

  task automatic test_div_zero();
    int da, bn;
    run_div(OP_DIVU, 32'd5, 32'd0, da, bn);
    checks++;
    if (da !== DIV_LATENCY || lo !== 32'hFFFF_FFFF || hi !== 32'd5 || div_zero !== 1'b1) begin
      errors++;
      $display("FAIL div_by_zero: lo=%h hi=%h dz=%b at %0d, required ffffffff 5 1 at %0d",
               lo, hi, div_zero, da, DIV_LATENCY);
    end
    @(negedge clk);
    checks++;
    if (div_zero !== 1'b1) begin
      errors++;
      $display("FAIL div_zero_sticky: dz=%b, required 1", div_zero);
    end
    start = 1'b1; op = OP_DIVU; a = 32'd9; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (div_zero !== 1'b0) begin
      errors++;
      $display("FAIL div_zero_clear_on_start: dz=%b, required 0", div_zero);
    end
    repeat (DIV_LATENCY - 1) @(negedge clk);
    checks++;
    if (done !== 1'b1 || lo !== 32'd3 || hi !== 32'd0) begin
      errors++;
      $display("FAIL divu_9_3: done=%b lo=%0d hi=%0d, required 1 3 0", done, lo, hi);
    end
  endtask

  task automatic test_signed();
    int da, bn;
    logic [31:0] ea, eb, q, r;
    run_div(OP_DIV, 32'hFFFF_FFF9, 32'd2, da, bn);
`ifdef HILO_DIV_SIGNED_EN
    q = 32'hFFFF_FFFD; r = 32'hFFFF_FFFF;
`else
    q = 32'h7FFF_FFFC; r = 32'd1;
`endif
    checks++;
    if (da !== DIV_LATENCY || lo !== q || hi !== r) begin
      errors++;
      $display("FAIL div_m7_2: lo=%h hi=%h at %0d, required %h %h at %0d", lo, hi, da, q, r, DIV_LATENCY);
    end
`ifdef HILO_DIV_SIGNED_EN
    run_div(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, da, bn);
    checks++;
    if (lo !== 32'h8000_0000 || hi !== 32'd0) begin
      errors++;
      $display("FAIL div_minint_m1: lo=%h hi=%h, required 80000000 0", lo, hi);
    end
`endif
    for (int i = 0; i < 16; i++) begin
      ea = $urandom;
      eb = ($urandom_range(0, 1) == 0) ? 32'($signed($urandom_range(0, 40)) - 20) : 32'($urandom);
      if (eb == 0) eb = 32'hFFFF_FFFB;
      model(OP_DIV, ea, eb, q, r);
      run_div(OP_DIV, ea, eb, da, bn);
      checks++;
      if (da !== DIV_LATENCY || lo !== q || hi !== r) begin
        errors++;
        $display("FAIL div_rand: %h/%h got lo=%h hi=%h, required lo=%h hi=%h", ea, eb, lo, hi, q, r);
      end
    end
  endtask

  task automatic test_mult_mt();
    int dones;
    logic [31:0] q, r;
    @(negedge clk);
    mult_we = 1'b1; mult_hi = 32'h1; mult_lo = 32'h2;
    @(negedge clk);
    mult_we = 1'b0;
    checks++;
    if (hi !== 32'h1 || lo !== 32'h2) begin
      errors++;
      $display("FAIL mult_capture: hi=%h lo=%h, required 1 2", hi, lo);
    end
    start = 1'b1; op = OP_MTHI; a = 32'hAB;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (hi !== 32'hAB || lo !== 32'h2 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL mthi: hi=%h lo=%h busy=%b done=%b, required ab 2 0 0", hi, lo, busy, done);
    end
    start = 1'b1; op = OP_MTLO; a = 32'hCD;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (hi !== 32'hAB || lo !== 32'hCD) begin
      errors++;
      $display("FAIL mtlo: hi=%h lo=%h, required ab cd", hi, lo);
    end
    // divide with mult_we and start pulsed while busy
    start = 1'b1; op = OP_DIVU; a = 32'd1000; b = 32'd10;
    dones = 0;
    for (int k = 1; k <= 45; k++) begin
      @(negedge clk);
      start = 1'b0; mult_we = 1'b0;
      if (k == 5) begin mult_we = 1'b1; mult_hi = 32'h77; mult_lo = 32'h88; end
      if (k == 7) begin start = 1'b1; op = OP_MTHI; a = 32'hDEAD; end
      if (k == 9) begin start = 1'b1; op = OP_DIVU; a = 32'd1; b = 32'd1; end
      if (k == 20) begin
        checks++;
        if (hi !== 32'hAB || lo !== 32'hCD) begin
          errors++;
          $display("FAIL busy_hold: hi=%h lo=%h, required ab cd", hi, lo);
        end
      end
      if (done) dones++;
      if (k == DIV_LATENCY) begin
        model(OP_DIVU, 32'd1000, 32'd10, q, r);
        checks++;
        if (done !== 1'b1 || lo !== q || hi !== r) begin
          errors++;
          $display("FAIL busy_ignore_result: done=%b lo=%0d hi=%0d, required 1 %0d %0d", done, lo, hi, q, r);
        end
      end
    end
    checks++;
    if (dones !== 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_done: dones=%0d busy=%b, required 1 0", dones, busy);
    end
  endtask

  task automatic test_start_mult_same();
    int da, bn;
    mult_we = 1'b1; mult_hi = 32'h1234; mult_lo = 32'h5678;
    run_div(OP_DIVU, 32'd8, 32'd2, da, bn);
    checks++;
    if (da !== DIV_LATENCY || lo !== 32'd4 || hi !== 32'd0) begin
      errors++;
      $display("FAIL start_beats_mult: lo=%h hi=%h at %0d, required 4 0 at %0d", lo, hi, da, DIV_LATENCY);
    end
  endtask

  task automatic test_back_to_back();
    int da, bn;
    logic [31:0] q, r;
    run_div(OP_DIVU, 32'd50, 32'd6, da, bn);
    // next start issued in the done cycle
    run_div(OP_DIVU, 32'hFFFF_0000, 32'd3, da, bn);
    model(OP_DIVU, 32'hFFFF_0000, 32'd3, q, r);
    checks++;
    if (da !== DIV_LATENCY || bn !== 33 || lo !== q || hi !== r) begin
      errors++;
      $display("FAIL back_to_back: done_at=%0d busy=%0d lo=%h hi=%h, required %0d 33 %h %h",
               da, bn, lo, hi, DIV_LATENCY, q, r);
    end
  endtask

  task automatic test_mid_reset();
    int da, bn, dones;
    @(negedge clk);
    mult_we = 1'b1; mult_hi = 32'h55; mult_lo = 32'h66;
    @(negedge clk);
    mult_we = 1'b0;
    start = 1'b1; op = OP_DIVU; a = 32'd999; b = 32'd4;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0 || done !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: busy=%b hi=%h lo=%h done=%b, required 0 0 0 0", busy, hi, lo, done);
    end
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) dones++;
    end
    checks++;
    if (dones !== 0) begin
      errors++;
      $display("FAIL mid_reset_abandon: done/busy seen %0d cycles, required 0", dones);
    end
    run_div(OP_DIVU, 32'd77, 32'd5, da, bn);
    checks++;
    if (da !== DIV_LATENCY || lo !== 32'd15 || hi !== 32'd2) begin
      errors++;
      $display("FAIL after_reset_div: lo=%0d hi=%0d at %0d, required 15 2 at %0d", lo, hi, da, DIV_LATENCY);
    end
  endtask

  initial begin
    test_reset();
    test_divu();
    test_div_zero();
    test_signed();
    test_mult_mt();
    test_start_mult_same();
    test_back_to_back();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
